// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - if_state_e   : fetch controller states
//   - PC_STEP      : byte distance between consecutive instructions
//   - BUBBLE_INSTR : value presented on Instruction when no live instruction
//   - RESET_PC_DEFAULT : default first fetch address after reset
package if_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      STALL = 2'd2,
      DRAIN = 2'd3
   } if_state_e;

   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] BUBBLE_INSTR     = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : if_pkg

// File: rtl/fetch_skid_slot.sv
// One-entry holding register for a fetched {pc, instr} pair.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   load_i              : capture pc_i/instr_i and mark the slot full
//   unload_i            : empty the slot (contents handed downstream)
//   clear_i             : discard the contents (redirect); highest priority
//   pc_i, instr_i       : word to capture
//   pc_o, instr_o       : held word (zero when empty)
//   valid_o             : slot is full
module fetch_skid_slot #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic          unload_i,
   input  logic          clear_i,
   input  logic [AW-1:0] pc_i,
   input  logic [DW-1:0] instr_i,
   output logic [AW-1:0] pc_o,
   output logic [DW-1:0] instr_o,
   output logic          valid_o
);

   logic [AW-1:0] pc_q,    pc_d;
   logic [DW-1:0] instr_q, instr_d;
   logic          valid_q, valid_d;

   // Next-state selection: clear beats load, load beats unload.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (clear_i || (unload_i && !load_i)) begin
         pc_d    = '0;
         instr_d = '0;
         valid_d = 1'b0;
      end else if (load_i) begin
         pc_d    = pc_i;
         instr_d = instr_i;
         valid_d = 1'b1;
      end else begin
         valid_d = valid_q;
      end
   end

   // Slot storage.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q    <= '0;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign pc_o    = pc_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule : fetch_skid_slot

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: generates the PC, requests instructions over a
// ready-handshake memory port and drives the IF/ID register (PC+4,
// Instruction, if_valid). Honours freeze, redirects on branch_taken, and
// parks one response in a skid slot when it arrives during a freeze.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   freeze                    : downstream does not consume this cycle
//   branch_taken/_address     : redirect pulse and target
//   imem_req/imem_addr        : fetch request, address held until imem_ready
//   imem_ready/imem_rdata     : response accepted / instruction word
//   PC, Instruction, if_valid : IF/ID register contents
// Optional build macro FETCH_PERF_CNT_EN adds saturating 32-bit counters
//   fetch_count (accepted, kept responses) and stall_count (frozen live cycles).
module instruction_fetch_unit
   import if_pkg::*;
#(
   parameter int unsigned             ADDRESS_LEN = 32,
   parameter int unsigned             DATA_LEN    = 32,
   parameter logic [ADDRESS_LEN-1:0]  RESET_PC    = ADDRESS_LEN'(RESET_PC_DEFAULT)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   freeze,
   input  logic                   branch_taken,
   input  logic [ADDRESS_LEN-1:0] branch_address,
   output logic                   imem_req,
   output logic [ADDRESS_LEN-1:0] imem_addr,
   input  logic                   imem_ready,
   input  logic [DATA_LEN-1:0]    imem_rdata,
   output logic [ADDRESS_LEN-1:0] PC,
   output logic [DATA_LEN-1:0]    Instruction,
   output logic                   if_valid
`ifdef FETCH_PERF_CNT_EN
  ,output logic [31:0]            fetch_count
  ,output logic [31:0]            stall_count
`endif
);

   localparam logic [ADDRESS_LEN-1:0] STEP   = ADDRESS_LEN'(PC_STEP);
   localparam logic [DATA_LEN-1:0]    BUBBLE = DATA_LEN'(BUBBLE_INSTR);

   if_state_e                state_q, state_d;
   logic [ADDRESS_LEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [ADDRESS_LEN-1:0]   drain_addr_q, drain_addr_d;
   logic [ADDRESS_LEN-1:0]   pc_q, pc_d;
   logic [DATA_LEN-1:0]      instr_q, instr_d;
   logic                     valid_q, valid_d;

   logic                     skid_load_s, skid_unload_s, skid_clear_s;
   logic [ADDRESS_LEN-1:0]   skid_pc_s;
   logic [DATA_LEN-1:0]      skid_instr_s;
   logic                     skid_valid_s;
   logic                     consume_s;

   assign consume_s = valid_q && !freeze;

   fetch_skid_slot #(
      .AW (ADDRESS_LEN),
      .DW (DATA_LEN)
   ) u_skid (
      .clk_i    (clk),
      .rst_i    (rst),
      .load_i   (skid_load_s),
      .unload_i (skid_unload_s),
      .clear_i  (skid_clear_s),
      .pc_i     (fetch_pc_q + STEP),
      .instr_i  (imem_rdata),
      .pc_o     (skid_pc_s),
      .instr_o  (skid_instr_s),
      .valid_o  (skid_valid_s)
   );

   // Controller next state, fetch PC and IF/ID register updates.
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      drain_addr_d  = drain_addr_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      valid_d       = valid_q;
      skid_load_s   = 1'b0;
      skid_unload_s = 1'b0;
      skid_clear_s  = 1'b0;

      // A consumed word leaves a bubble unless something replaces it below.
      if (consume_s) begin
         pc_d    = '0;
         instr_d = BUBBLE;
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end

      if (branch_taken) begin
         // Redirect wins over freeze and ready; state depends on origin.
         pc_d         = '0;
         instr_d      = BUBBLE;
         valid_d      = 1'b0;
         skid_clear_s = 1'b1;
         fetch_pc_d   = branch_address;
         case (state_q)
            REQ: begin
               if (imem_ready) begin
                  state_d = REQ;
               end else begin
                  // Keep the in-flight request at its old address.
                  state_d      = DRAIN;
                  drain_addr_d = fetch_pc_q;
               end
            end
            DRAIN:   state_d = DRAIN;
            IDLE:    state_d = REQ;
            STALL:   state_d = REQ;
            default: state_d = IDLE;
         endcase
      end else begin
         case (state_q)
            IDLE: begin
               state_d = REQ;
            end
            REQ: begin
               if (imem_ready) begin
                  fetch_pc_d = fetch_pc_q + STEP;
                  if (!valid_q || !freeze) begin
                     pc_d    = fetch_pc_q + STEP;
                     instr_d = imem_rdata;
                     valid_d = 1'b1;
                     state_d = REQ;
                  end else begin
                     skid_load_s = 1'b1;
                     state_d     = STALL;
                  end
               end else begin
                  state_d = REQ;
               end
            end
            STALL: begin
               if (!freeze) begin
                  pc_d          = skid_pc_s;
                  instr_d       = skid_instr_s;
                  valid_d       = skid_valid_s;
                  skid_unload_s = 1'b1;
                  state_d       = REQ;
               end else begin
                  state_d = STALL;
               end
            end
            DRAIN: begin
               if (imem_ready) begin
                  state_d = REQ;
               end else begin
                  state_d = DRAIN;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Controller and IF/ID register state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         fetch_pc_q   <= RESET_PC;
         drain_addr_q <= '0;
         pc_q         <= '0;
         instr_q      <= BUBBLE;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         drain_addr_q <= drain_addr_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         valid_q      <= valid_d;
      end
   end

   // Memory port decode: DRAIN keeps presenting the pre-redirect address.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = fetch_pc_q;
      case (state_q)
         REQ: begin
            imem_req  = 1'b1;
            imem_addr = fetch_pc_q;
         end
         DRAIN: begin
            imem_req  = 1'b1;
            imem_addr = drain_addr_q;
         end
         IDLE:    imem_req = 1'b0;
         STALL:   imem_req = 1'b0;
         default: imem_req = 1'b0;
      endcase
   end

   assign PC          = pc_q;
   assign Instruction = instr_q;
   assign if_valid    = valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;
   logic        fetch_inc_s;
   logic        stall_inc_s;

   assign fetch_inc_s = (state_q == REQ) && imem_ready && !branch_taken;
   assign stall_inc_s = valid_q && freeze;

   // Saturating performance counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         if (fetch_inc_s && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (stall_inc_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign stall_count = stall_cnt_q;
`endif

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit. Memory returns
// addr ^ 32'hE5A0_0000 so every expected instruction is derivable by hand.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_address;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] PC;
   logic [31:0] Instruction;
   logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] MEM_KEY = 32'hE5A0_0000;

   assign imem_rdata = imem_addr ^ MEM_KEY;

   instruction_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .freeze         (freeze),
      .branch_taken   (branch_taken),
      .branch_address (branch_address),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .PC             (PC),
      .Instruction    (Instruction),
      .if_valid       (if_valid)
`ifdef FETCH_PERF_CNT_EN
     ,.fetch_count    (fetch_count)
     ,.stall_count    (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic v);
      check({tag, ".PC"},    PC,          pc);
      check({tag, ".INSTR"}, Instruction, ins);
      check({tag, ".VALID"}, {31'd0, if_valid}, {31'd0, v});
   endtask

   task automatic check_req(input string tag, input logic r, input logic [31:0] a);
      check({tag, ".REQ"}, {31'd0, imem_req}, {31'd0, r});
      if (r) begin
         check({tag, ".ADDR"}, imem_addr, a);
      end
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0;
      branch_address = 32'd0; imem_ready = 1'b1;
      step(); step();
      check_out("rst", 32'd0, 32'd0, 1'b0);
      check_req("rst", 1'b0, 32'd0);

      // Streaming with zero-wait memory.
      rst = 1'b0;
      step();
      check_req("idle2req", 1'b1, 32'd0);
      check_out("idle2req", 32'd0, 32'd0, 1'b0);
      step();
      check_out("s0", 32'd4, 32'h0 ^ MEM_KEY, 1'b1);
      check_req("s0", 1'b1, 32'd4);
      step();
      check_out("s1", 32'd8, 32'h4 ^ MEM_KEY, 1'b1);
      check_req("s1", 1'b1, 32'd8);
      step();
      check_out("s2", 32'd12, 32'h8 ^ MEM_KEY, 1'b1);
      check_req("s2", 1'b1, 32'd12);

      // Freeze for three cycles: response to 12 parks in the skid.
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_out("frz", 32'd12, 32'h8 ^ MEM_KEY, 1'b1);
         check_req("frz", 1'b0, 32'd0);
      end
      freeze = 1'b0;
      step();
      check_out("skid_out", 32'd16, 32'hC ^ MEM_KEY, 1'b1);
      check_req("skid_out", 1'b1, 32'd16);
      step();
      check_out("resume", 32'd20, 32'h10 ^ MEM_KEY, 1'b1);
      check_req("resume", 1'b1, 32'd20);

      // Memory wait states: address stable, output drains to a bubble.
      imem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_req("wait", 1'b1, 32'd20);
         check_out("wait", 32'd0, 32'd0, 1'b0);
      end
      imem_ready = 1'b1;
      step();
      check_out("wait_done", 32'd24, 32'h14 ^ MEM_KEY, 1'b1);
      step();
      step();
      check_out("pre_br", 32'h20, 32'h1C ^ MEM_KEY, 1'b1);
      check_req("pre_br", 1'b1, 32'h20);

      // Branch while the request to 0x20 is outstanding.
      imem_ready = 1'b0;
      step();
      check_out("br_wait", 32'd0, 32'd0, 1'b0);
      branch_taken = 1'b1; branch_address = 32'h100;
      step();
      branch_taken = 1'b0;
      check_req("drain", 1'b1, 32'h20);
      check_out("drain", 32'd0, 32'd0, 1'b0);
      step();
      check_req("drain2", 1'b1, 32'h20);
      imem_ready = 1'b1;
      step();
      check_out("discard", 32'd0, 32'd0, 1'b0);
      check_req("discard", 1'b1, 32'h100);
      step();
      check_out("br_tgt", 32'h104, 32'h100 ^ MEM_KEY, 1'b1);
      check_req("br_tgt", 1'b1, 32'h104);

      // Branch with freeze and a full skid.
      freeze = 1'b1;
      step();
      check_req("stall2", 1'b0, 32'd0);
      check_out("stall2", 32'h104, 32'h100 ^ MEM_KEY, 1'b1);
      branch_taken = 1'b1; branch_address = 32'h200;
      step();
      branch_taken = 1'b0; freeze = 1'b0;
      check_out("br_frz", 32'd0, 32'd0, 1'b0);
      check_req("br_frz", 1'b1, 32'h200);
      step();
      check_out("br_frz_tgt", 32'h204, 32'h200 ^ MEM_KEY, 1'b1);

      // Reset in the middle of a waiting request.
      imem_ready = 1'b0;
      step();
      check_req("pre_rst", 1'b1, 32'h204);
      rst = 1'b1;
      #1;
      check_req("async_rst", 1'b0, 32'd0);
      check_out("async_rst", 32'd0, 32'd0, 1'b0);
      imem_ready = 1'b1;
      step();
      rst = 1'b0;
      step();
      check_req("restart", 1'b1, 32'd0);
      step();
      check_out("restart", 32'd4, 32'h0 ^ MEM_KEY, 1'b1);
`ifdef FETCH_PERF_CNT_EN
      check("fetch_count", fetch_count, 32'd1);
      check("stall_count", stall_count, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_instruction_fetch_unit

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Instruction fetch stage of the ARM968E-S pipeline. It generates the program counter, issues requests to instruction memory over a ready-handshake port, and presents PC+4 and the instruction to the IF/ID pipeline register. It honours the pipeline freeze and redirects on a taken branch from EXE. A one-entry skid slot absorbs a memory response that arrives while the downstream register is frozen.

Parameters:
ADDRESS_LEN, 32, PC and memory address width
DATA_LEN, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
freeze  in  1  hazard stall; downstream does not consume this cycle
branch_taken  in  1  single-cycle redirect pulse from EXE
branch_address  in  ADDRESS_LEN  redirect target, valid with branch_taken
imem_req  out  1  fetch request
imem_addr  out  ADDRESS_LEN  fetch address, stable while imem_req=1
imem_ready  in  1  response valid and request accepted this cycle
imem_rdata  in  DATA_LEN  instruction, valid with imem_ready
PC  out  ADDRESS_LEN  fetched address + 4
Instruction  out  DATA_LEN  fetched instruction; 0 when if_valid=0
if_valid  out  1  PC/Instruction hold a live instruction

Behaviour:
- Reset: state=IDLE, fetch_pc=RESET_PC, PC=0, Instruction=0, if_valid=0, skid empty, imem_req=0.
- States:
  - IDLE: imem_req=0. Always goes to REQ on the next cycle.
  - REQ: imem_req=1, imem_addr=fetch_pc.
  - STALL: skid full, imem_req=0.
  - DRAIN: imem_req=1, discarding the outstanding response after a redirect.
- Consume: the output is consumed on any edge with if_valid=1 and freeze=0.
- REQ, imem_ready=1, no branch:
  - fetch_pc += 4 (wraps mod 2^ADDRESS_LEN).
  - If output is empty or being consumed: PC<=fetch_pc+4, Instruction<=imem_rdata, if_valid<=1. Stay in REQ.
  - Else (if_valid=1 and freeze=1): skid<=response, go to STALL.
- REQ, imem_ready=0: hold imem_addr. If output is consumed, clear it (if_valid<=0, PC/Instruction<=0).
- STALL: when freeze=0, output<=skid, skid cleared, go to REQ.
- Throughput: zero-wait memory and no freeze give one instruction per cycle. Latency is 1 cycle from the imem_ready edge to the output.
- Branch (has priority over freeze and ready): output and skid are cleared, fetch_pc<=branch_address.
  - From REQ without imem_ready, go to DRAIN. The request stays asserted at the old address until ready.
  - From REQ with imem_ready, the response is discarded and the state goes to REQ at the new address.
  - From STALL or IDLE, go to REQ.
- DRAIN, imem_ready=1: discard the response, go to REQ with the new fetch_pc.
- A branch while in DRAIN updates fetch_pc and stays in DRAIN.
- Reset mid-transaction drops the outstanding request; memory must tolerate this.
- No request is ever withdrawn or changed before imem_ready, except by reset.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds 32-bit outputs fetch_count (increments on each accepted, non-discarded response) and stall_count (increments on each cycle with if_valid=1 and freeze=1). Both saturate at all-ones and clear on reset.
- Undefined: neither port nor counter exists.

Decomposition:
- Shared package if_pkg: state enum (IDLE, REQ, STALL, DRAIN), PC_STEP=4, BUBBLE_INSTR=0, RESET_PC default.
- Sub-module fetch_skid_slot: a one-entry register with load, unload and clear, holding {pc, instr, valid}.

Test Plan:
- Reset release, imem_ready tied 1 -> imem_addr 0,4,8,… each cycle; PC=4,8,12 with matching Instruction; if_valid=1 from the 2nd cycle after reset.
- freeze=1 for 3 cycles with ready=1 -> one response goes to skid, state STALL, imem_req=0; output unchanged; after freeze drops, the skid word appears, then fetch resumes at the next address.
- ready delayed 4 cycles -> imem_addr stable throughout; if_valid=0 after the prior word is consumed.
- branch_taken to 0x100 while a request to 0x20 waits for ready -> DRAIN; the 0x20 response is discarded; next request is 0x100; output PC=0x104.
- branch_taken together with freeze=1 and full skid -> output and skid cleared, if_valid=0, next request at the branch target.
- rst asserted mid-REQ -> imem_req=0, all outputs 0 immediately; restart from RESET_PC.
